// File: rtl/kbd_display_ctrl.sv
`default_nettype none
// kbd_display_ctrl: pops PS/2 scan codes from the receiver FIFO, parses make/break/E0
// sequences and maintains the shift, caps, held-key and press-count display state.
module kbd_display_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       scan_code,
  output logic             key_en,
  output logic             shift,
  output logic             is_caps,
  output logic [CNT_W-1:0] press_count
);

  localparam logic [7:0] C_BRK   = 8'hF0;
  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] C_LSHFT = 8'h12;
  localparam logic [7:0] C_RSHFT = 8'h59;
  localparam logic [7:0] C_CAPS  = 8'h58;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic [7:0]         scan_code_q, scan_code_d;
  logic               key_en_q, key_en_d;
  logic               lshift_q, lshift_d;
  logic               rshift_q, rshift_d;
  logic               caps_held_q, caps_held_d;
  logic               is_caps_q, is_caps_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  assign accept = ready & nextdata_n_q;

  always_comb begin
    state_d      = state_q;
    nextdata_n_d = ~accept;
    scan_code_d  = scan_code_q;
    key_en_d     = key_en_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    caps_held_d  = caps_held_q;
    is_caps_d    = is_caps_q;
    cnt_d        = cnt_q;

    // Overflow means the byte stream can no longer be trusted; drop all held state.
    if (overflow) begin
      state_d     = S_IDLE;
      key_en_d    = 1'b0;
      lshift_d    = 1'b0;
      rshift_d    = 1'b0;
      caps_held_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (data == C_BRK) begin
            state_d = S_BRK;
          end else if (data == C_EXT) begin
            state_d = S_EXT;
          end else if (data == C_LSHFT) begin
            lshift_d = 1'b1;
          end else if (data == C_RSHFT) begin
            rshift_d = 1'b1;
          end else if (data == C_CAPS) begin
            if (!caps_held_q) begin
              is_caps_d   = ~is_caps_q;
              caps_held_d = 1'b1;
            end
          end else if (!(key_en_q && data == scan_code_q)) begin
            scan_code_d = data;
            key_en_d    = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (data == C_LSHFT) begin
            lshift_d = 1'b0;
          end else if (data == C_RSHFT) begin
            rshift_d = 1'b0;
          end else if (data == C_CAPS) begin
            caps_held_d = 1'b0;
          end else if (data == scan_code_q) begin
            key_en_d = 1'b0;
          end
        end
        S_EXT: begin
          state_d = (data == C_BRK) ? S_EXT_BRK : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nextdata_n_q <= 1'b1;
      scan_code_q  <= 8'h00;
      key_en_q     <= 1'b0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      caps_held_q  <= 1'b0;
      is_caps_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      scan_code_q  <= scan_code_d;
      key_en_q     <= key_en_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      caps_held_q  <= caps_held_d;
      is_caps_q    <= is_caps_d;
      cnt_q        <= cnt_d;
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign scan_code   = scan_code_q;
  assign key_en      = key_en_q;
  assign shift       = lshift_q | rshift_q;
  assign is_caps     = is_caps_q;
  assign press_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_display_ctrl.sv
`default_nettype none
// tb_kbd_display_ctrl: scoreboard bench; a byte-level reference model predicts the
// display outputs after each popped byte and a monitor compares on every pop strobe.
module tb_kbd_display_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       data = 8'h00;
  logic             ready = 1'b0;
  logic             overflow = 1'b0;
  logic             nextdata_n;
  logic [7:0]       scan_code;
  logic             key_en;
  logic             shift;
  logic             is_caps;
  logic [CNT_W-1:0] press_count;

  kbd_display_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .ready       (ready),
    .overflow    (overflow),
    .nextdata_n  (nextdata_n),
    .scan_code   (scan_code),
    .key_en      (key_en),
    .shift       (shift),
    .is_caps     (is_caps),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sc;
    logic       ke;
    logic       sh;
    logic       ca;
    logic [7:0] pc;
  } obs_t;

  int   errors = 0;
  int   checks = 0;
  obs_t sb[$];

  // Reference model: keyboard state plus the list of prefix bytes seen so far.
  logic [7:0] m_sc;
  logic       m_ke, m_ls, m_rs, m_ch, m_caps;
  int         m_pc;
  logic [7:0] pfx[$];

  function automatic void model_reset();
    m_sc = 8'h00; m_ke = 0; m_ls = 0; m_rs = 0; m_ch = 0; m_caps = 0; m_pc = 0;
    pfx.delete();
  endfunction

  function automatic obs_t exp_now();
    obs_t o;
    o.sc = m_sc; o.ke = m_ke; o.sh = m_ls | m_rs; o.ca = m_caps; o.pc = 8'(m_pc);
    return o;
  endfunction

  function automatic void model_flush();
    m_ke = 0; m_ls = 0; m_rs = 0; m_ch = 0;
    pfx.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ovf);
    bit ext, brk;
    if (ovf) begin
      model_flush();
      return;
    end
    if ((pfx.size() == 0 && (b == 8'hF0 || b == 8'hE0)) ||
        (pfx.size() == 1 && pfx[0] == 8'hE0 && b == 8'hF0)) begin
      pfx.push_back(b);
      return;
    end
    ext = 0; brk = 0;
    foreach (pfx[i]) begin
      if (pfx[i] == 8'hE0) ext = 1;
      if (pfx[i] == 8'hF0) brk = 1;
    end
    pfx.delete();
    if (ext) return;
    if (brk) begin
      if (b == 8'h12) m_ls = 0;
      else if (b == 8'h59) m_rs = 0;
      else if (b == 8'h58) m_ch = 0;
      else if (b == m_sc) m_ke = 0;
    end else begin
      if (b == 8'h12) m_ls = 1;
      else if (b == 8'h59) m_rs = 1;
      else if (b == 8'h58) begin
        if (!m_ch) begin m_caps = !m_caps; m_ch = 1; end
      end else if (!(m_ke && b == m_sc)) begin
        m_sc = b; m_ke = 1; m_pc = (m_pc + 1) % 256;
      end
    end
  endfunction

  task automatic send(input logic [7:0] b, input bit ovf);
    bit got;
    got = 0;
    @(negedge clk);
    data = b; ready = 1'b1; overflow = ovf;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (nextdata_n == 1'b0) got = 1;
    end
    ready = 1'b0; overflow = 1'b0;
    if (got) begin
      model_byte(b, ovf);
      sb.push_back(exp_now());
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout byte=%h: no pop strobe seen", b);
    end
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i], 1'b0);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_nextdata_n"}, nextdata_n, 1);
    check_val({tag, "_scan_code"}, scan_code, 0);
    check_val({tag, "_key_en"}, key_en, 0);
    check_val({tag, "_shift"}, shift, 0);
    check_val({tag, "_is_caps"}, is_caps, 0);
    check_val({tag, "_press_count"}, press_count, 0);
  endtask

  // Monitor: every pop strobe carries the effect of one popped byte.
  logic prev_low = 1'b0;
  always @(negedge clk) begin
    obs_t act, e;
    if (nextdata_n == 1'b0) begin
      checks++;
      if (prev_low) begin
        errors++;
        $display("FAIL pop_width: nextdata_n low for two consecutive cycles");
      end
      act = {scan_code, key_en, shift, is_caps, press_count};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got %h with no byte outstanding", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL outputs: got sc=%h ke=%b sh=%b ca=%b pc=%0d, expected sc=%h ke=%b sh=%b ca=%b pc=%0d",
                   act.sc, act.ke, act.sh, act.ca, act.pc, e.sc, e.ke, e.sh, e.ca, e.pc);
        end
      end
    end
    prev_low = (nextdata_n == 1'b0);
  end

  logic [7:0] keys[7] = '{8'h1C, 8'h32, 8'h24, 8'h12, 8'h59, 8'h58, 8'h1C};

  initial begin
    logic [7:0] k;
    model_reset();
    #12;
    check_reset_outputs("reset_start");
    @(negedge clk);
    reset = 1'b0;

    send_seq('{8'h1C, 8'hF0, 8'h1C});
    send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h32});
    send_seq('{8'h12});
    send_seq('{8'h58, 8'h58, 8'hF0, 8'h58});
    send_seq('{8'h58, 8'hF0, 8'h58});
    send_seq('{8'hF0, 8'h12});
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});

    for (int i = 0; i < 256; i++) begin
      k = (i % 2 == 0) ? 8'h1C : 8'h32;
      send(k, 1'b0);
      send(8'hF0, 1'b0);
      send(k, 1'b0);
    end
    @(negedge clk);
    check_val("wrap_press_count", press_count, m_pc);

    send_seq('{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h59});
    send(8'h2B, 1'b1);
    @(negedge clk);
    check_val("ovf_key_en", key_en, 0);
    check_val("ovf_shift", shift, 0);
    check_val("ovf_is_caps", is_caps, 1);

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send(keys[$urandom_range(0, 6)], 1'b0);
        4, 5, 6: begin
          send(8'hF0, 1'b0);
          send(keys[$urandom_range(0, 6)], 1'b0);
        end
        7: send_seq('{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B});
        8: send(8'($urandom_range(0, 255)), 1'b0);
        default: begin
          if ($urandom_range(0, 1) == 1) send(8'($urandom_range(0, 255)), 1'b1);
          else begin
            @(negedge clk);
            overflow = 1'b1;
            @(negedge clk);
            overflow = 1'b0;
            model_flush();
          end
        end
      endcase
    end

    send(8'hF0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send(8'h1C, 1'b0);
    @(negedge clk);
    check_val("after_reset_key_en", key_en, 1);
    check_val("after_reset_press_count", press_count, 1);

    repeat (3) @(negedge clk);
    check_val("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
